// File: rtl/uart_tx_fifo.sv
// Byte-queued 8N1 UART transmitter, LSB first, idling high on TX.
// Bytes wait in a small circular FIFO and frames are sent back to back with no idle gap.

// Generic circular FIFO. A pushed entry is visible at the head one clock later.
// Backpressure: a push while full is dropped. A pop while empty is ignored.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    // full is taken from the count before any pop this cycle.
    // A push while full is dropped even on a pop cycle.
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// UART transmitter. TX falls one clock after a push into an empty idle block.
// Each frame takes 10*BAUD_CYCLES clocks. A push while full is dropped.
module uart_tx_fifo #(
    parameter int BAUD_CYCLES = 2604,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       full,
    output logic       tx_idle
);
    localparam int              BW        = $clog2(BAUD_CYCLES);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_CYCLES - 1);
    localparam logic [0:0]      IDLE      = 1'b0;
    localparam logic [0:0]      TRANSMIT  = 1'b1;

    logic [0:0]    state;
    logic [8:0]    sr;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    head_dat;
    logic          empty;
    logic          shift;
    logic          frame_end;
    logic          load;

    fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (trmt),
        .push_dat (tx_data),
        .pop      (load),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

    assign shift     = (state == TRANSMIT) && (baud_cnt == BAUD_LAST);
    assign frame_end = shift && (bit_cnt == 4'd9);
    // At frame end a waiting byte is loaded directly, so its start bit follows the stop bit with no gap.
    assign load      = !empty && ((state == IDLE) || frame_end);

    assign TX      = sr[0];
    assign tx_idle = (state == IDLE) && empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sr       <= 9'h1FF;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= frame_end;
            if (load) begin
                sr       <= {head_dat, 1'b0};
                baud_cnt <= '0;
                bit_cnt  <= '0;
                state    <= TRANSMIT;
            end else if (state == TRANSMIT) begin
                if (shift) begin
                    // Shifting in ones leaves TX high once the stop bit has been sent.
                    sr       <= {1'b1, sr[8:1]};
                    bit_cnt  <= bit_cnt + 4'd1;
                    baud_cnt <= '0;
                    if (frame_end) begin
                        state <= IDLE;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-schedule reference model plus a TX line decoder.
module tb_uart_tx_fifo;
    localparam int B     = 16;
    localparam int D     = 4;
    localparam int FRAME = 10 * B;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       full;
    logic       tx_idle;

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_CYCLES(B), .DEPTH(D)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .full    (full),
        .tx_idle (tx_idle)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending bytes and the schedule of the frame on the line.
    int         cyc = 0;
    logic [7:0] pend[$];
    logic [7:0] exp_load_q[$];
    bit         active;
    int         cur_start;
    int         free_edge;
    logic [7:0] cur_dat;
    logic       exp_tx, exp_done, exp_full, exp_idle;

    // Line decoder working only from the observed TX pin.
    bit         rx_busy;
    int         rx_t;
    logic [7:0] rx_sh;
    logic       tx_prev;
    logic [7:0] rx_q[$];
    logic       samp_q[$];
    int         fall_q[$];
    int         done_q[$];

    logic       exp_a5 [10];
    int         push_edge;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qb(input logic [7:0] q[$], input int i);
        if (i < q.size()) return 32'(q[i]);
        return 32'hxxxxxxxx;
    endfunction

    function automatic int qi(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_load_q.delete();
        active    = 1'b0;
        free_edge = 0;
        rx_busy   = 1'b0;
        tx_prev   = 1'b1;
    endtask

    task automatic model_edge(input logic t, input logic [7:0] d);
        int  p;
        int  k;
        bit  acc;
        bit  in_frame;
        cyc++;
        p        = pend.size();
        acc      = t && (p < D);
        exp_done = active && (cyc == cur_start + FRAME);
        if (p > 0 && cyc >= free_edge) begin
            cur_dat   = pend.pop_front();
            exp_load_q.push_back(cur_dat);
            cur_start = cyc;
            free_edge = cyc + FRAME;
            active    = 1'b1;
        end
        if (acc) pend.push_back(d);
        in_frame = active && (cyc < cur_start + FRAME);
        if (in_frame) begin
            k = (cyc - cur_start) / B;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = cur_dat[k-1];
            else             exp_tx = 1'b1;
        end else begin
            exp_tx = 1'b1;
        end
        exp_full = (pend.size() == D);
        exp_idle = (pend.size() == 0) && !in_frame;
    endtask

    task automatic decode();
        logic [31:0] e;
        if (!rx_busy) begin
            if (tx_prev === 1'b1 && TX === 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t % B == B / 2) begin
                samp_q.push_back(TX);
                if (rx_t / B >= 1 && rx_t / B <= 8) begin
                    rx_sh = {TX, rx_sh[7:1]};
                end else if (rx_t / B == 9) begin
                    chk1("stop_bit", TX, 1'b1);
                    if (exp_load_q.size() > 0) e = 32'(exp_load_q.pop_front());
                    else                       e = 32'h100;
                    chkn("rx_byte", 32'(rx_sh), e);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
        tx_prev = TX;
    endtask

    task automatic cycle(input logic t, input logic [7:0] d);
        trmt    = t;
        tx_data = d;
        @(posedge clk);
        model_edge(t, d);
        #1;
        chk1("tx", TX, exp_tx);
        chk1("tx_done", tx_done, exp_done);
        chk1("full", full, exp_full);
        chk1("tx_idle", tx_idle, exp_idle);
        if (tx_done === 1'b1) done_q.push_back(cyc);
        decode();
    endtask

    task automatic clear_obs();
        rx_q.delete();
        samp_q.delete();
        fall_q.delete();
        done_q.delete();
    endtask

    task automatic run_to_frame_end();
        for (int g = 0; g < 2 * FRAME && cyc + 1 < free_edge; g++) cycle(1'b0, 8'h00);
    endtask

    initial begin
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst_n   = 1'b0;
        trmt    = 1'b0;
        tx_data = 8'h00;
        model_reset();

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tx", TX, 1'b1);
        chk1("rst_done", tx_done, 1'b0);
        chk1("rst_full", full, 1'b0);
        chk1("rst_idle", tx_idle, 1'b1);
        rst_n = 1'b1;
        repeat (100) cycle(1'b0, 8'h00);
        chkn("idle_done_cnt", done_q.size(), 0);

        // Single byte A5
        clear_obs();
        cycle(1'b1, 8'hA5);
        push_edge = cyc;
        repeat (200) cycle(1'b0, 8'h00);
        chkn("a5_fall_cnt", fall_q.size(), 1);
        chkn("a5_fall_edge", qi(fall_q, 0), push_edge + 1);
        for (int i = 0; i < 10; i++) begin
            chk1($sformatf("a5_bit%0d", i), (i < samp_q.size()) ? samp_q[i] : 1'bx, exp_a5[i]);
        end
        chkn("a5_done_cnt", done_q.size(), 1);
        chkn("a5_done_gap", qi(done_q, 0) - qi(fall_q, 0), FRAME);
        chkn("a5_byte", qb(rx_q, 0), 32'hA5);
        chk1("a5_idle_after", tx_idle, 1'b1);

        // Back-to-back frames
        clear_obs();
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'h3C);
        repeat (520) cycle(1'b0, 8'h00);
        chkn("b2b_fall_cnt", fall_q.size(), 3);
        chkn("b2b_gap1", qi(fall_q, 1) - qi(fall_q, 0), FRAME);
        chkn("b2b_gap2", qi(fall_q, 2) - qi(fall_q, 1), FRAME);
        chkn("b2b_done_cnt", done_q.size(), 3);
        chkn("b2b_done_gap", qi(done_q, 2) - qi(done_q, 1), FRAME);
        chkn("b2b_total", qi(done_q, 2) - qi(fall_q, 0), 3 * FRAME);
        chkn("b2b_byte0", qb(rx_q, 0), 32'h00);
        chkn("b2b_byte1", qb(rx_q, 1), 32'hFF);
        chkn("b2b_byte2", qb(rx_q, 2), 32'h3C);

        // Overflow: fifth queued byte is dropped
        clear_obs();
        cycle(1'b1, 8'hC3);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        for (int v = 1; v <= 5; v++) begin
            cycle(1'b1, 8'(v));
            if (v == 3) chk1("ovf_full3", full, 1'b0);
            if (v == 4) chk1("ovf_full4", full, 1'b1);
        end
        chk1("ovf_full5", full, 1'b1);
        run_to_frame_end();
        chk1("ovf_full_preload", full, 1'b1);
        cycle(1'b0, 8'h00);
        chk1("ovf_full_postload", full, 1'b0);
        repeat (4 * FRAME + 40) cycle(1'b0, 8'h00);
        chkn("ovf_cnt", rx_q.size(), 5);
        chkn("ovf_b0", qb(rx_q, 0), 32'hC3);
        for (int v = 1; v <= 4; v++) chkn($sformatf("ovf_b%0d", v), qb(rx_q, v), 32'(v));

        // Push on the pop cycle
        clear_obs();
        cycle(1'b1, 8'h5A);
        cycle(1'b0, 8'h00);
        cycle(1'b1, 8'hA1);
        cycle(1'b1, 8'hA2);
        cycle(1'b1, 8'hA3);
        cycle(1'b1, 8'hA4);
        chk1("pp_full", full, 1'b1);
        run_to_frame_end();
        cycle(1'b1, 8'hEE);
        chk1("pp_drop_4to3", full, 1'b0);
        run_to_frame_end();
        cycle(1'b1, 8'hDD);
        chk1("pp_keep3", full, 1'b0);
        cycle(1'b1, 8'hD0);
        chk1("pp_full_again", full, 1'b1);
        repeat (5 * FRAME + 40) cycle(1'b0, 8'h00);
        chkn("pp_cnt", rx_q.size(), 7);
        chkn("pp_b0", qb(rx_q, 0), 32'h5A);
        chkn("pp_b1", qb(rx_q, 1), 32'hA1);
        chkn("pp_b4", qb(rx_q, 4), 32'hA4);
        chkn("pp_b5", qb(rx_q, 5), 32'hDD);
        chkn("pp_b6", qb(rx_q, 6), 32'hD0);

        // Reset during data bit 4 with two bytes queued
        clear_obs();
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        for (int g = 0; g < 2 * FRAME && !(active && cyc - cur_start == 5 * B + 8); g++) cycle(1'b0, 8'h00);
        chk1("mid_tx_low", TX, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk1("mid_rst_tx", TX, 1'b1);
        chk1("mid_rst_done", tx_done, 1'b0);
        chk1("mid_rst_idle", tx_idle, 1'b1);
        chk1("mid_rst_full", full, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        clear_obs();
        repeat (300) cycle(1'b0, 8'h00);
        chkn("mid_no_frame", fall_q.size(), 0);
        chkn("mid_no_done", done_q.size(), 0);
        chk1("mid_idle", tx_idle, 1'b1);

        // Random traffic against the model
        clear_obs();
        for (int i = 0; i < 1500; i++) begin
            cycle(logic'($urandom_range(0, 99) < 12), 8'($urandom));
        end
        for (int g = 0; g < 8 * FRAME && exp_idle !== 1'b1; g++) cycle(1'b0, 8'h00);
        repeat (20) cycle(1'b0, 8'h00);
        chk1("rand_idle", tx_idle, 1'b1);
        chkn("rand_all_decoded", exp_load_q.size(), 0);
        chkn("rand_done_vs_frames", done_q.size(), fall_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter: the serial-out counterpart of the team's UART receiver. It is fed by the wrapper or command layer and drives the TX pin toward the Bluetooth module.
- Accepts bytes through a small FIFO so software-side logic can queue a multi-byte response without waiting on each frame.
- Frame format is 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
- Default timing is 19200 baud from the 50 MHz clock.

Parameters:
- BAUD_CYCLES, 2604, clocks per bit period. Must be >= 4.
- DEPTH, 4, FIFO entries. Must be a power of 2, >= 2.

Ports:
- clk  in  1  50 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- trmt  in  1  push strobe; tx_data is written into the FIFO this cycle if full=0.
- tx_data  in  8  byte to queue.
- TX  out  1  serial output; idles high.
- tx_done  out  1  single-cycle pulse when the stop bit of a frame completes.
- full  out  1  FIFO holds DEPTH entries.
- tx_idle  out  1  high when state=IDLE and the FIFO is empty.

Behaviour:
- **Clocking/reset:** one clock domain. Every flop resets asynchronously on rst_n low.
- **Reset values:**
  - TX=1, tx_done=0, full=0, tx_idle=1.
  - FIFO count=0 and pointers=0.
  - State=IDLE, shift register=9'h1FF, baud_cnt=0, bit_cnt=0.
- **Reset mid-frame:** TX returns high immediately (asynchronously) and all queued bytes are discarded.
- **FIFO:**
  - Circular buffer; count is $clog2(DEPTH)+1 bits wide.
  - Push when trmt && !full.
  - trmt while full is ignored: the byte is dropped and no state changes.
  - Pop when the transmitter loads a byte.
  - Simultaneous push and pop: count is unchanged and both pointers advance. full is evaluated from the pre-pop count, so a push while full is still dropped even on a pop cycle.
  - Pointers wrap modulo DEPTH.
- **State machine (IDLE, TRANSMIT):**
  - **IDLE:** if the FIFO is non-empty, load and go to TRANSMIT.
    - Load: shift register <= {head_byte, 1'b0}; baud_cnt<=0; bit_cnt<=0; pop the FIFO.
  - **TRANSMIT:** baud_cnt increments each clock. When baud_cnt==BAUD_CYCLES-1, assert shift.
    - On shift: shift register <= {1'b1, sr[8:1]}, bit_cnt+1, baud_cnt<=0.
  - TX = sr[0] (registered source), so TX never glitches.
  - **Frame end:** on the shift that makes bit_cnt reach 10, pulse tx_done for exactly one cycle.
    - If the FIFO is non-empty in that same cycle, load the next byte and stay in TRANSMIT. The next start bit follows the stop bit with zero idle clocks.
    - Otherwise go to IDLE. TX stays 1 because the shift register fill is all ones.
- **Latency and duration:**
  - trmt sampled at edge N with FIFO empty and IDLE: count=1 after edge N, load at edge N+1, so TX falls at edge N+1.
  - Each frame lasts exactly 10*BAUD_CYCLES clocks.
- **Counter widths:** baud_cnt is $clog2(BAUD_CYCLES) bits wide; bit_cnt is 4 bits.
- **Outputs:** tx_idle and full are combinational from registered state/count.

Test Plan:
- **Reset/idle:** BAUD_CYCLES=16, DEPTH=4, hold rst_n low 3 clocks then release with no trmt for 100 clocks -> TX=1, tx_idle=1, full=0, tx_done never asserts.
- **Single byte:** trmt with tx_data=8'hA5 -> TX falls one edge after the push edge. Sampling at bit centres (clock 8 of each 16) gives 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 160 clocks after TX fell; tx_idle=1 afterwards.
- **Back-to-back:** push 8'h00, 8'hFF, 8'h3C on consecutive cycles -> three contiguous frames totalling 480 clocks with no extra idle high between the stop bit and the next start bit. tx_done pulses 3 times, 160 clocks apart.
- **Full/overflow:**
  - With the transmitter busy on byte 1, push 5 more bytes 8'h01..8'h05 -> full asserts after the 4th; 8'h05 is dropped.
  - Decoded output is the first byte, then 8'h01–8'h04.
  - full deasserts the cycle after byte 8'h01 is loaded.
- **Push/pop same cycle:** FIFO full, trmt asserted on the exact cycle a load pops -> new byte dropped, count goes 4->3.
  - With FIFO at 3 entries, push and load in the same cycle -> count stays 3.
- **Reset mid-frame:** assert rst_n low during data bit 4 with 2 bytes queued -> TX=1 asynchronously, tx_done stays 0. After release, tx_idle=1 and no frame is emitted.
